timer_pit: RTL



---
 rtl/timer_pit_if.sv | 16 +
 rtl/timer_pit.sv | 137 +++++++++++++
 2 files changed

// File: rtl/timer_pit_if.sv
// Bus-side signals of the programmable interval timer.
// The controller drives ctrl/sel/din; the timer returns read data, lane enables and its interrupt.
interface timer_pit_if #(
  parameter int W = 16
);
  logic [15:0]  ctrl;
  logic         sel;
  logic [W-1:0] din;
  logic [W-1:0] dout;
  logic         ud_t;
  logic         ld_t;
  logic         int_req;

  modport master (output ctrl, sel, din, input dout, ud_t, ld_t, int_req);
  modport slave  (input ctrl, sel, din, output dout, ud_t, ld_t, int_req);
endinterface

// File: rtl/timer_pit.sv
// Programmable interval timer: 16-bit down-counter with prescaler, auto-reload and level IRQ.
// Bus accesses are decoded on one mem_ce edge and committed on the next mem_ce edge.
module timer_pit #(
  parameter int W  = 16,
  parameter int PW = 8
) (
  input  logic      clk,
  input  logic      rst,
  timer_pit_if.slave bus
);

  logic mem_ce, hit;
  logic ud_we_q, ld_we_q, ud_t_q, ld_t_q;
  logic [4:0] addr_q;

  logic [W-1:0]  reload_q, reload_d, count_q, count_d;
  logic [PW-1:0] prescale_q, prescale_d, pcnt_q, pcnt_d;
  logic en_q, en_d, auto_q, auto_d, ie_q, ie_d, tc_q, tc_d;
  logic wr_lo, wr_hi, tick;
  logic [W-1:0] dout_mux;
  logic ctrl_unused;

  assign mem_ce      = bus.ctrl[7];
  assign hit         = bus.sel & bus.ctrl[6];
  assign ctrl_unused = ^{bus.ctrl[15:12], bus.ctrl[0], addr_q[4:2]};

  always_ff @(posedge clk) begin
    if (rst) begin
      ud_we_q <= 1'b0;
      ld_we_q <= 1'b0;
      ud_t_q  <= 1'b1;
      ld_t_q  <= 1'b1;
      addr_q  <= '0;
    end else if (mem_ce) begin
      ud_we_q <= hit & bus.ctrl[9];
      ld_we_q <= hit & bus.ctrl[8];
      ud_t_q  <= ~(hit & ~bus.ctrl[11]);
      ld_t_q  <= ~(hit & ~bus.ctrl[10]);
      addr_q  <= bus.ctrl[5:1];
    end
  end

  // Order inside this block encodes the same-cycle priorities: W1C before TC set,
  // tick updates before register writes so bus writes win.
  always_comb begin
    wr_lo      = ld_we_q & mem_ce;
    wr_hi      = ud_we_q & mem_ce;
    tick       = en_q & (pcnt_q == prescale_q);
    reload_d   = reload_q;
    count_d    = count_q;
    prescale_d = prescale_q;
    en_d       = en_q;
    auto_d     = auto_q;
    ie_d       = ie_q;
    tc_d       = tc_q;

    if (wr_hi && addr_q[1:0] == 2'd3 && bus.din[8]) tc_d = 1'b0;

    if (tick) begin
      if (count_q == '0) begin
        tc_d = 1'b1;
        if (auto_q) count_d = reload_q;
        else        en_d    = 1'b0;
      end else begin
        count_d = count_q - W'(1);
      end
    end

    unique case (addr_q[1:0])
      2'd0: begin
        if (wr_lo) reload_d[7:0]   = bus.din[7:0];
        if (wr_hi) reload_d[W-1:8] = bus.din[W-1:8];
      end
      2'd1: begin
        if (wr_lo) count_d[7:0]   = bus.din[7:0];
        if (wr_hi) count_d[W-1:8] = bus.din[W-1:8];
      end
      2'd2: begin
        if (wr_lo) prescale_d = bus.din[PW-1:0];
      end
      default: begin
        if (wr_lo) begin
          en_d   = bus.din[0];
          auto_d = bus.din[1];
          ie_d   = bus.din[2];
        end
      end
    endcase

    // pcnt restarts from zero on enable and stays zero while disabled.
    if (!en_q || !en_d || tick) pcnt_d = '0;
    else                        pcnt_d = pcnt_q + PW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      reload_q   <= '1;
      count_q    <= '1;
      prescale_q <= '0;
      pcnt_q     <= '0;
      en_q       <= 1'b0;
      auto_q     <= 1'b0;
      ie_q       <= 1'b0;
      tc_q       <= 1'b0;
    end else begin
      reload_q   <= reload_d;
      count_q    <= count_d;
      prescale_q <= prescale_d;
      pcnt_q     <= pcnt_d;
      en_q       <= en_d;
      auto_q     <= auto_d;
      ie_q       <= ie_d;
      tc_q       <= tc_d;
    end
  end

  always_comb begin
    dout_mux = '0;
    unique case (addr_q[1:0])
      2'd0: dout_mux = reload_q;
      2'd1: dout_mux = count_q;
      2'd2: dout_mux[PW-1:0] = prescale_q;
      default: begin
        dout_mux[0] = en_q;
        dout_mux[1] = auto_q;
        dout_mux[2] = ie_q;
        dout_mux[8] = tc_q;
      end
    endcase
  end

  assign bus.dout    = dout_mux;
  assign bus.ud_t    = ud_t_q;
  assign bus.ld_t    = ld_t_q;
  assign bus.int_req = tc_q & ie_q;

endmodule
